// File: rtl/spi_master_if.sv
// Bus bundle between a host and the SPI master: word handshake, received word and the SPI pins.
// The master modport is the controller side; slave is the host/pad side.
interface spi_master_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              cs_n;

    modport master (
        input  tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
    );

    modport slave (
        output tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, one word per chip-select frame.
// Frame: SETUP (CLK_DIV cycles) -> XFER (2*DATA_W sclk half-periods) -> HOLD (CLK_DIV cycles).
module spi_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_master_if.master  bus
);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rdy_q, rdy_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              rx_vld_q, rx_vld_d;
    logic              div_end;

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        rx_vld_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_valid && rdy_q) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    tx_sh_d = bus.tx_data;
                    mosi_d  = bus.tx_data[DATA_W-1];
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = XFER;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            XFER: begin
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Rising edge samples miso; falling edge advances mosi unless it ends the word.
                    if (!sclk_q) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.miso};
                        bit_d   = bit_q + 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_q[DATA_W-2];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    div_d     = '0;
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    rx_vld_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            rx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            rdy_q     <= rdy_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            rx_vld_q  <= rx_vld_d;
        end
    end

    assign bus.tx_ready = rdy_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_vld_q;
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the transfer word width in bits (legal range 2..32).
REQ-002 Parameter CLK_DIV, default 2, SHALL set the SCLK half-period in clk cycles (legal range >= 1).
REQ-003 clk  input  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 tx_data  input  DATA_W  SHALL carry the word to transmit, sampled on handshake.
REQ-006 tx_valid  input  1  SHALL request a transfer.
REQ-007 tx_ready  output  1  SHALL indicate that a word can be accepted.
REQ-008 rx_data  output  DATA_W  SHALL hold the last word received on miso.
REQ-009 rx_valid  output  1  SHALL pulse for one cycle when rx_data updates.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 sclk  output  1  SHALL be the SPI serial clock.
REQ-012 mosi  output  1  SHALL be the serial data out.
REQ-013 miso  input  1  SHALL be the serial data in, synchronous to clk.
REQ-014 cs_n  output  1  SHALL be the active-low chip select.

Function
REQ-015 The block SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, one word per cs_n assertion.
REQ-016 The FSM SHALL have states IDLE, SETUP, XFER, HOLD; tx_ready = 1 only in IDLE.
REQ-017 A handshake SHALL occur on a cycle with tx_valid=1 and tx_ready=1; tx_data is loaded into the shift register, and the state goes to SETUP on the next cycle.
REQ-018 On entering SETUP, cs_n SHALL go 0 and mosi SHALL present tx_data[DATA_W-1]; SETUP lasts CLK_DIV cycles with sclk=0.
REQ-019 In XFER, a divider counter SHALL toggle sclk every CLK_DIV cycles, for exactly 2*DATA_W toggles.
REQ-020 On each sclk rising edge, the miso value SHALL be shifted into the LSB of the receive register.
REQ-021 On each sclk falling edge except the last, mosi SHALL advance to the next lower bit.
REQ-022 After the last falling edge, the state SHALL go to HOLD for CLK_DIV cycles with sclk=0 and mosi held.
REQ-023 At the end of HOLD, the following SHALL occur in the same cycle: cs_n=1, rx_data loaded, rx_valid=1, state=IDLE.
REQ-024 cs_n low duration SHALL equal CLK_DIV*(2*DATA_W+2) cycles; for the defaults this is 36 cycles.
REQ-025 tx_valid while busy SHALL be ignored, with no effect on the ongoing transfer; tx_data changes after the handshake SHALL have no effect.
REQ-026 A handshake SHALL be accepted in the first cycle of IDLE after a transfer, so back-to-back words have exactly one cs_n=1 cycle between them.
REQ-027 The bit counter SHALL be ceil(log2(DATA_W+1)) bits wide, and the divider counter ceil(log2(CLK_DIV+1)) bits wide; no wrap-around SHALL occur within legal ranges.
REQ-028 rx_data SHALL hold its value until the next completed transfer.

Reset
REQ-029 While rst=1 at a rising clk edge: state=IDLE, cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0, busy=0, tx_ready=0; tx_ready returns to 1 the cycle after rst deasserts.
REQ-030 Reset SHALL take priority over any handshake in the same cycle.
REQ-031 Reset mid-transfer SHALL abort immediately, with no rx_valid pulse; cs_n SHALL go 1 on the reset edge.

Verification
REQ-032 DATA_W=8, CLK_DIV=2, miso looped to mosi, send 0xA5 -> mosi bit sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; rx_valid high 1 cycle; cs_n low 36 cycles.
REQ-033 miso tied 1, send 0x00 -> rx_data=0xFF, mosi constant 0, exactly 8 sclk rising edges.
REQ-034 Send 0x3C, hold tx_valid=1 with tx_data=0xFF throughout the transfer -> only 0x3C is shifted out; a second transfer starts one cycle after cs_n rises.
REQ-035 rst asserted at the 5th sclk rising edge -> next cycle cs_n=1, sclk=0, no rx_valid; a new send of 0x81 then completes correctly.
REQ-036 CLK_DIV=1, DATA_W=4, loopback, send 0x9 -> rx_data=0x9, cs_n low 10 cycles.
